usb_fs_packet_tx: RTL and testbench



---
 rtl/usbdev_pkg.sv | 34 +++
 rtl/usb_nrzi_stuff_enc.sv | 45 ++++
 rtl/usb_fs_packet_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_usb_fs_packet_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbdev_pkg.sv
// Shared definitions for the usbdev line-level transmit path: TX state
// encoding, SYNC pattern, J/K line mapping and PID byte values.
package usbdev_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J,
        GAP
    } tx_state_e;

    // KJKJKJKK once NRZI-coded, sent LSB first.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    // Map a logical J/K symbol onto {dp, dm}. Full speed: J = D+ high.
    // Low speed: J = D- high. K is always the inverse of J.
    function automatic logic [1:0] line_sym(input logic is_j, input logic low_speed);
        return (is_j ^ low_speed) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/usb_nrzi_stuff_enc.sv
// NRZI encoder with bit-stuff run tracking. 'line' is the {dp,dm} value the
// line takes if bit_in is sent now; the level and run count commit on bit_tick.
module usb_nrzi_stuff_enc
    import usbdev_pkg::*;
#(
    parameter int STUFF_RUN = 6,
    parameter int LOW_SPEED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_tick,
    input  logic       clear,
    output logic       stuff_req,
    output logic [1:0] line
);

    localparam int CW = $clog2(STUFF_RUN + 1);

    logic [CW-1:0] run_cnt;
    logic          level_j;
    logic          next_j;

    // A 0 toggles the line level, a 1 holds it.
    assign next_j    = bit_in ? level_j : ~level_j;
    assign line      = line_sym(next_j, LOW_SPEED != 0);
    assign stuff_req = (run_cnt == CW'(STUFF_RUN));

    // Commit the NRZI level and the run of consecutive 1s per emitted bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            level_j <= 1'b1;
        end else if (clear) begin
            run_cnt <= '0;
            level_j <= 1'b1;
        end else if (bit_tick) begin
            level_j <= next_j;
            run_cnt <= bit_in ? run_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/usb_fs_packet_tx.sv
// USB packet transmitter: byte handshake in, SYNC + stuffed NRZI data + EOP
// out on dp/dm with output enable. Every line symbol lasts OVERSAMPLE clocks
// and all outputs come straight from flops.
module usb_fs_packet_tx
    import usbdev_pkg::*;
#(
    parameter int OVERSAMPLE   = 4,
    parameter int LOW_SPEED    = 0,
    parameter int EOP_SE0_BITS = 2,
    parameter int GAP_BITS     = 2,
    parameter int STUFF_RUN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dp,
    output logic       dm,
    output logic       oe,
    output logic       busy,
    output logic       underrun
);

    localparam int              PW         = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0]   PHASE_PRE  = PW'(OVERSAMPLE - 2);
    localparam logic [7:0]      EOP_LAST   = 8'(EOP_SE0_BITS - 1);
    localparam logic [7:0]      GAP_LAST   = 8'(GAP_BITS - 1);
    localparam logic [1:0]      LINE_J     = line_sym(1'b1, LOW_SPEED != 0);

    tx_state_e     state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [7:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    byte_q, byte_n;
    logic          last_q, last_n;
    logic          oe_n, busy_n, ready_n, underrun_n;
    logic [1:0]    line_n;

    logic          bit_tick;
    logic          boundary_pending;
    logic          next_bit;
    logic          enc_tick;
    logic          enc_clear;
    logic          stuff_req;
    logic [1:0]    enc_line;

    assign bit_tick = (state != IDLE) && (phase == PHASE_LAST);

    // The coming tick ends a byte with no stuff bit owed and more bytes
    // expected, so in_ready must be raised for exactly that tick cycle.
    assign boundary_pending = ((state == DATA) || (state == STUFF)) &&
                              (bit_cnt == 8'd7) && !stuff_req && !last_q;

    usb_nrzi_stuff_enc #(
        .STUFF_RUN (STUFF_RUN),
        .LOW_SPEED (LOW_SPEED)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (next_bit),
        .bit_tick  (enc_tick),
        .clear     (enc_clear),
        .stuff_req (stuff_req),
        .line      (enc_line)
    );

    // Select the bit that would be sent next; the FSM decides whether to use it.
    always_comb begin
        next_bit = 1'b0;
        case (state)
            IDLE:        next_bit = SYNC_PATTERN[0];
            SYNC:        next_bit = (bit_cnt == 8'd7) ? byte_q[0]
                                                      : SYNC_PATTERN[bit_cnt[2:0] + 3'd1];
            DATA, STUFF: begin
                if ((state == DATA) && stuff_req) next_bit = 1'b0;
                else if (bit_cnt != 8'd7)         next_bit = byte_q[bit_cnt[2:0] + 3'd1];
                else                              next_bit = in_data[0];
            end
            default:     next_bit = 1'b0;
        endcase
    end

    // Next-state, handshake and next-symbol logic; symbols change on bit ticks.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_n    = state;
        phase_n    = (state == IDLE || bit_tick) ? '0 : phase + 1'b1;
        bit_cnt_n  = bit_cnt;
        byte_n     = byte_q;
        last_n     = last_q;
        oe_n       = oe;
        busy_n     = busy;
        ready_n    = 1'b0;
        underrun_n = 1'b0;
        line_n     = {dp, dm};
        enc_tick   = 1'b0;
        enc_clear  = 1'b0;

        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    byte_n    = in_data;
                    last_n    = in_last;
                    state_n   = SYNC;
                    bit_cnt_n = 8'd0;
                    oe_n      = 1'b1;
                    busy_n    = 1'b1;
                    ready_n   = 1'b0;
                    enc_tick  = 1'b1;
                    line_n    = enc_line;
                end
            end

            SYNC: begin
                if (bit_tick) begin
                    enc_tick = 1'b1;
                    line_n   = enc_line;
                    if (bit_cnt == 8'd7) begin
                        state_n   = DATA;
                        bit_cnt_n = 8'd0;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end

            DATA, STUFF: begin
                if (!bit_tick) begin
                    ready_n = boundary_pending && (phase == PHASE_PRE);
                end else if ((state == DATA) && stuff_req) begin
                    state_n  = STUFF;
                    enc_tick = 1'b1;
                    line_n   = enc_line;
                end else if (bit_cnt != 8'd7) begin
                    state_n   = DATA;
                    bit_cnt_n = bit_cnt + 8'd1;
                    enc_tick  = 1'b1;
                    line_n    = enc_line;
                end else if (last_q) begin
                    state_n   = EOP_SE0;
                    bit_cnt_n = 8'd0;
                    line_n    = LINE_SE0;
                end else if (in_valid && in_ready) begin
                    byte_n    = in_data;
                    last_n    = in_last;
                    state_n   = DATA;
                    bit_cnt_n = 8'd0;
                    enc_tick  = 1'b1;
                    line_n    = enc_line;
                end else begin
                    // Source ran dry mid-packet: truncate with an EOP.
                    underrun_n = 1'b1;
                    state_n    = EOP_SE0;
                    bit_cnt_n  = 8'd0;
                    line_n     = LINE_SE0;
                end
            end

            EOP_SE0: begin
                if (bit_tick) begin
                    if (bit_cnt == EOP_LAST) begin
                        state_n = EOP_J;
                        line_n  = LINE_J;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end

            EOP_J: begin
                if (bit_tick) begin
                    state_n   = GAP;
                    bit_cnt_n = 8'd0;
                    oe_n      = 1'b0;
                    enc_clear = 1'b1;
                end
            end

            GAP: begin
                if (bit_tick) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset parks the line at idle J, undriven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= 8'd0;
            byte_q   <= 8'd0;
            last_q   <= 1'b0;
            oe       <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            underrun <= 1'b0;
            {dp, dm} <= LINE_J;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            byte_q   <= byte_n;
            last_q   <= last_n;
            oe       <= oe_n;
            busy     <= busy_n;
            in_ready <= ready_n;
            underrun <= underrun_n;
            {dp, dm} <= line_n;
        end
    end

endmodule

// File: tb/tb_usb_fs_packet_tx.sv
// Bench for usb_fs_packet_tx: a full-speed and a low-speed instance share the
// same stimulus; captured line samples are compared with a symbol list built
// from the USB framing rules (SYNC, stuffing, NRZI, EOP).
module tb_usb_fs_packet_tx;
    import usbdev_pkg::*;

    localparam int OS       = 4;
    localparam int EOP_BITS = 2;
    localparam int GAP_B    = 2;
    localparam int RUN      = 6;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [1:0] sym_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, dp_fs, dm_fs, oe_fs, busy_fs, underrun;
    logic       ready_ls, dp_ls, dm_ls, oe_ls, busy_ls, underrun_ls;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usb_fs_packet_tx #(.OVERSAMPLE(OS), .LOW_SPEED(0), .EOP_SE0_BITS(EOP_BITS),
                       .GAP_BITS(GAP_B), .STUFF_RUN(RUN)) dut_fs (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .dp(dp_fs), .dm(dm_fs), .oe(oe_fs), .busy(busy_fs),
        .underrun(underrun));

    usb_fs_packet_tx #(.OVERSAMPLE(OS), .LOW_SPEED(1), .EOP_SE0_BITS(EOP_BITS),
                       .GAP_BITS(GAP_B), .STUFF_RUN(RUN)) dut_ls (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(ready_ls), .dp(dp_ls), .dm(dm_ls), .oe(oe_ls), .busy(busy_ls),
        .underrun(underrun_ls));

    // Reference: line symbols, one per bit time, for a packet of bytes.
    task automatic model(input byte_q_t b, input bit ls, output sym_q_t s);
        logic [1:0] j;
        bit         lvl_j;
        int         run;
        bit         bits[$];
        j     = ls ? 2'b01 : 2'b10;
        s     = {};
        lvl_j = 1'b1;
        run   = 0;
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        foreach (b[k]) for (int i = 0; i < 8; i++) bits.push_back(b[k][i]);
        foreach (bits[i]) begin
            if (!bits[i]) lvl_j = !lvl_j;
            s.push_back(lvl_j ? j : ~j);
            run = bits[i] ? run + 1 : 0;
            if (run == RUN) begin
                lvl_j = !lvl_j;
                s.push_back(lvl_j ? j : ~j);
                run = 0;
            end
        end
        for (int i = 0; i < EOP_BITS; i++) s.push_back(2'b00);
        s.push_back(j);
    endtask

    // Index of the first captured cycle that disagrees with the symbol list, or -1.
    function automatic int first_diff(input sym_q_t got, input sym_q_t exp);
        for (int i = 0; i < got.size(); i++)
            if ((i / OS) >= exp.size() || got[i] !== exp[i / OS]) return i;
        if (got.size() != exp.size() * OS) return got.size();
        return -1;
    endfunction

    task automatic send(input byte_q_t b, input bit last_final, output int acc_cyc, output bit to);
        int w;
        to      = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < b.size(); i++) begin
            in_data  = b[i];
            in_last  = last_final && (i == b.size() - 1);
            in_valid = 1'b1;
            w = 0;
            while (in_ready !== 1'b1 && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (w >= 400) to = 1'b1;
            if (i == 0) acc_cyc = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic capture(output sym_q_t fs, output sym_q_t ls, output int first_oe,
                           output int busy_delay, output int readies, output int unders,
                           output bit to);
        int w;
        fs = {};
        ls = {};
        readies = 0;
        unders  = 0;
        to      = 1'b0;
        w = 0;
        while (oe_fs !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) to = 1'b1;
        first_oe = cyc;
        w = 0;
        while (oe_fs === 1'b1 && w < 3000) begin
            fs.push_back({dp_fs, dm_fs});
            ls.push_back({dp_ls, dm_ls});
            if (in_ready && busy_fs) readies++;
            if (underrun) unders++;
            @(negedge clk);
            w++;
        end
        if (w >= 3000) to = 1'b1;
        busy_delay = 0;
        while (busy_fs === 1'b1 && busy_delay < 200) begin
            if (in_ready) readies++;
            if (underrun) unders++;
            @(negedge clk);
            busy_delay++;
        end
    endtask

    task automatic run_packet(input string name, input byte_q_t b, input bit last_final,
                              input int exp_oe);
        sym_q_t efs, els, gfs, gls;
        int     acc, first_oe, bdel, rdy, und, d;
        bit     to_s, to_c;
        @(negedge clk);
        fork
            send(b, last_final, acc, to_s);
            capture(gfs, gls, first_oe, bdel, rdy, und, to_c);
        join
        model(b, 1'b0, efs);
        model(b, 1'b1, els);

        checks++;
        if ((to_s || to_c) !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: send=%0d capture=%0d, required 0/0", name, to_s, to_c);
        end
        checks++;
        if (first_oe !== acc) begin
            errors++;
            $display("FAIL %s latency: oe first seen cycle %0d, required %0d", name, first_oe, acc);
        end
        checks++;
        if (gfs.size() !== efs.size() * OS) begin
            errors++;
            $display("FAIL %s oe_len: %0d clk, required %0d", name, gfs.size(), efs.size() * OS);
        end
        if (exp_oe >= 0) begin
            checks++;
            if (gfs.size() !== exp_oe) begin
                errors++;
                $display("FAIL %s oe_len_const: %0d clk, required %0d", name, gfs.size(), exp_oe);
            end
        end
        checks++;
        d = first_diff(gfs, efs);
        if (d !== -1) begin
            errors++;
            $display("FAIL %s line_fs: first bad clk %0d got %b required %b", name, d,
                     (d < gfs.size()) ? gfs[d] : 2'bxx,
                     ((d / OS) < efs.size()) ? efs[d / OS] : 2'bxx);
        end
        checks++;
        d = first_diff(gls, els);
        if (d !== -1) begin
            errors++;
            $display("FAIL %s line_ls: first bad clk %0d got %b required %b", name, d,
                     (d < gls.size()) ? gls[d] : 2'bxx,
                     ((d / OS) < els.size()) ? els[d / OS] : 2'bxx);
        end
        checks++;
        if (bdel !== GAP_B * OS) begin
            errors++;
            $display("FAIL %s busy_tail: busy fell %0d clk after oe, required %0d", name, bdel, GAP_B * OS);
        end
        checks++;
        if (rdy !== (last_final ? b.size() - 1 : b.size())) begin
            errors++;
            $display("FAIL %s boundary_ready: %0d cycles, required %0d", name, rdy,
                     last_final ? b.size() - 1 : b.size());
        end
        checks++;
        if (und !== (last_final ? 0 : 1)) begin
            errors++;
            $display("FAIL %s underrun: %0d pulses, required %0d", name, und, last_final ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({oe_fs, busy_fs, in_ready, underrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: oe,busy,ready,underrun=%b required 0000",
                     {oe_fs, busy_fs, in_ready, underrun});
        end
        checks++;
        if ({dp_fs, dm_fs, dp_ls, dm_ls} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_line: fs=%b%b ls=%b%b required fs=10 ls=01", dp_fs, dm_fs, dp_ls, dm_ls);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, ready_ls, busy_fs} !== 3'b110) begin
            errors++;
            $display("FAIL idle_ready: ready_fs,ready_ls,busy=%b required 110", {in_ready, ready_ls, busy_fs});
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        in_data  = 8'hA5;
        in_last  = 1'b0;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        in_data = 8'h3C;
        repeat (45) @(negedge clk);
        checks++;
        if (oe_fs !== 1'b1) begin
            errors++;
            $display("FAIL mid_pkt_oe: oe=%b before reset, required 1", oe_fs);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({oe_fs, busy_fs, in_ready, underrun, oe_ls, busy_ls, underrun_ls} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: %b required 0000000",
                     {oe_fs, busy_fs, in_ready, underrun, oe_ls, busy_ls, underrun_ls});
        end
        checks++;
        if ({dp_fs, dm_fs, dp_ls, dm_ls} !== 4'b1001) begin
            errors++;
            $display("FAIL async_reset_line: fs=%b%b ls=%b%b required fs=10 ls=01", dp_fs, dm_fs, dp_ls, dm_ls);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_packet("after_reset", '{PID_DATA1}, 1'b1, -1);
    endtask

    task automatic test_low_speed();
        run_packet("ls_c3", '{PID_DATA0}, 1'b1, 76);
        checks++;
        if ({dp_ls, dm_ls, oe_ls, busy_ls, ready_ls} !== 5'b01001) begin
            errors++;
            $display("FAIL ls_idle: dp,dm,oe,busy,ready=%b required 01001",
                     {dp_ls, dm_ls, oe_ls, busy_ls, ready_ls});
        end
    endtask

    task automatic test_random();
        byte_q_t b;
        int      n;
        bit      lf;
        for (int p = 0; p < 8; p++) begin
            b = {};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                b.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            lf = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_packet($sformatf("rand%0d", p), b, lf, -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_packet("ack_d2", '{PID_ACK}, 1'b1, 76);
        run_packet("stuff_ff", '{8'hFF}, 1'b1, 80);
        run_packet("back_to_back", '{PID_SETUP, 8'h00}, 1'b1, 108);
        run_packet("underrun_69", '{PID_IN}, 1'b0, 76);
        test_reset_mid();
        test_low_speed();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
